// File: rtl/router_pkg.sv
// router_pkg: shared flit type, defaults and read-FSM state encoding for the
// router input buffer.
package router_pkg;

  localparam int unsigned TAM_FLIT_DEFAULT = 16;

  typedef logic [TAM_FLIT_DEFAULT-1:0] flit_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_HDR     = 3'd2,
    S_SIZE    = 3'd3,
    S_PAYLOAD = 3'd4,
    S_END     = 3'd5
  } rd_state_e;

  // States in which the head flit may be offered to the crossbar.
  function automatic logic is_xfer_state(input rd_state_e s);
    return (s == S_HDR) || (s == S_SIZE) || (s == S_PAYLOAD);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: circular flit store with head/tail pointers and occupancy count.
// Storage is not reset; only pointers and count are.
module router_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_c,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Writes into a full buffer and reads from an empty one are ignored.
  assign wr_ok  = wr_en && (count != CNT_W'(DEPTH));
  assign rd_ok  = rd_en && (count != '0);
  assign head_c = mem[head_ptr];

  // Flit storage, written at the tail.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[tail_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (wr_ok) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_input_buffer.sv
// router_input_buffer: credit-based input buffer of a NoC router port.
// Buffers upstream flits, requests routing for each packet and streams the
// header, size and payload flits to the crossbar.
// Optional feature: define ROUTER_BUF_STATS_EN to add the 32-bit pkt_count
// output counting completed packets.
module router_input_buffer
  import router_pkg::*;
#(
  parameter int unsigned TAM_FLIT     = TAM_FLIT_DEFAULT,
  parameter int unsigned BUFFER_DEPTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  input  logic [TAM_FLIT-1:0] data_in,
  output logic                credit_o,
  output logic                h,
  input  logic                ack_h,
  output logic                data_av,
  output logic [TAM_FLIT-1:0] data,
  input  logic                data_ack,
  output logic                sender
`ifdef ROUTER_BUF_STATS_EN
  ,
  output logic [31:0]         pkt_count
`endif
);

  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

  rd_state_e           state;
  logic [TAM_FLIT-1:0] head_c;
  logic [TAM_FLIT-1:0] pay_cnt;
  logic [CNT_W-1:0]    count;
  logic                wr_en_c;
  logic                pop_c;
  logic                wr_q;
  logic                head_ready_c;
  logic                end_entry_c;

  router_fifo #(
    .WIDTH (TAM_FLIT),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en_c),
    .wr_data (data_in),
    .rd_en   (pop_c),
    .head_c  (head_c),
    .count   (count)
  );

  // Upstream handshake: accept only while a slot is free.
  assign credit_o = (count < CNT_W'(BUFFER_DEPTH));
  assign wr_en_c  = rx && credit_o;

  // A flit written on the last edge is the head only when it is alone in the
  // buffer; hold it back one cycle so it is never offered on the write edge.
  assign head_ready_c = (count > CNT_W'(1)) || ((count == CNT_W'(1)) && !wr_q);

  // Crossbar side: offer head flit in transfer states, zero data otherwise.
  assign data_av = is_xfer_state(state) && head_ready_c;
  assign data    = data_av ? head_c : '0;
  assign pop_c   = data_av && data_ack;

  // Last flit of a packet leaves on this edge.
  assign end_entry_c = pop_c &&
                       (((state == S_SIZE) && (head_c == '0)) ||
                        ((state == S_PAYLOAD) && (pay_cnt <= TAM_FLIT'(1))));

  // Remembers whether the previous edge wrote a flit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_en_c;
    end
  end

  // Read FSM: routing request, then header/size/payload transfer, then a
  // one-cycle gap before the next packet. h and sender are registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      h       <= 1'b0;
      sender  <= 1'b0;
      pay_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_REQ;
            h     <= 1'b1;
          end
        end
        S_REQ: begin
          if (ack_h) begin
            state  <= S_HDR;
            h      <= 1'b0;
            sender <= 1'b1;
          end
        end
        S_HDR: begin
          if (pop_c) begin
            state <= S_SIZE;
          end
        end
        S_SIZE: begin
          if (pop_c) begin
            pay_cnt <= head_c;
            if (end_entry_c) begin
              state  <= S_END;
              sender <= 1'b0;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (pop_c) begin
            if (pay_cnt != '0) begin
              pay_cnt <= pay_cnt - TAM_FLIT'(1);
            end
            if (end_entry_c) begin
              state  <= S_END;
              sender <= 1'b0;
            end
          end
        end
        S_END: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          h      <= 1'b0;
          sender <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROUTER_BUF_STATS_EN
  // Completed-packet counter, wraps modulo 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_count <= '0;
    end else if (end_entry_c) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_input_buffer.sv
// tb_router_input_buffer: directed vector tables, corner-case sequences and
// randomized traffic checked against a queue-based packet model.
module tb_router_input_buffer;
  import router_pkg::*;

  localparam int unsigned W     = TAM_FLIT_DEFAULT;
  localparam int unsigned DEPTH = 16;

  logic  clock    = 1'b0;
  logic  reset    = 1'b0;
  logic  rx       = 1'b0;
  flit_t data_in  = '0;
  logic  ack_h    = 1'b0;
  logic  data_ack = 1'b0;
  logic  credit_o;
  logic  h;
  logic  data_av;
  flit_t data;
  logic  sender;
`ifdef ROUTER_BUF_STATS_EN
  logic [31:0] pkt_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  router_input_buffer #(
    .TAM_FLIT     (W),
    .BUFFER_DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .data_in  (data_in),
    .credit_o (credit_o),
    .h        (h),
    .ack_h    (ack_h),
    .data_av  (data_av),
    .data     (data),
    .data_ack (data_ack),
    .sender   (sender)
`ifdef ROUTER_BUF_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic c, input logic hh,
                            input logic av, input flit_t d, input logic s);
    check({tag, ".credit_o"}, 32'(credit_o), 32'(c));
    check({tag, ".h"},        32'(h),        32'(hh));
    check({tag, ".data_av"},  32'(data_av),  32'(av));
    check({tag, ".data"},     32'(data),     32'(d));
    check({tag, ".sender"},   32'(sender),   32'(s));
  endtask

  task automatic do_reset(input bit chk);
    reset    = 1'b0;
    rx       = 1'b0;
    data_in  = '0;
    ack_h    = 1'b0;
    data_ack = 1'b0;
    #1;
    if (chk) check_outs("reset.during", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Directed per-cycle vectors.
  typedef struct {
    bit    rst;
    logic  rx;
    flit_t din;
    logic  ack_h;
    logic  data_ack;
    logic  credit;
    logic  h;
    logic  av;
    flit_t data;
    logic  sender;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic x, flit_t di, logic ah, logic da,
                              logic ec, logic eh, logic eav, flit_t ed, logic es);
    vec_t v;
    v.rst = r; v.rx = x; v.din = di; v.ack_h = ah; v.data_ack = da;
    v.credit = ec; v.h = eh; v.av = eav; v.data = ed; v.sender = es;
    return v;
  endfunction

  // Full-buffer sequence flit values: one 16-flit packet plus a 17th extra.
  function automatic flit_t full_flit(input int i);
    if (i == 0)  return 16'h0ABC;
    if (i == 1)  return 16'h000E;
    if (i == 16) return 16'hDEAD;
    return flit_t'(16'h1000 + i);
  endfunction

  // Behavioural model: accepted flits with the edge they were written on.
  typedef struct {
    flit_t v;
    int    t;
  } ent_t;

  ent_t  mq[$];
  flit_t src[$];
  int    edge_no;
  int    phase;
  int    rem;
  bit    expect_end;

  task automatic run_traffic(input int gen_cycles, input int max_pkts, input string tag);
    int    pkts      = 0;
    int    stall     = 0;
    int    max_stall = 0;
    bit    drained   = 0;
    int    sz;
    flit_t din;
    logic  pop;
    logic  wr;
    ent_t  e;
    mq.delete();
    src.delete();
    phase = 0; rem = 0; expect_end = 0; edge_no = 0;
    for (int cyc = 0; cyc < gen_cycles + 2000; cyc++) begin
      check({tag, ".credit_o"}, 32'(credit_o), 32'(mq.size() < DEPTH));
      if (expect_end) begin
        check({tag, ".end_sender"}, 32'(sender), 32'd0);
        check({tag, ".end_av"}, 32'(data_av), 32'd0);
        expect_end = 0;
      end
      if (data_av) begin
        if (mq.size() == 0) begin
          check({tag, ".av_on_empty"}, 32'(data_av), 32'd0);
        end else begin
          check({tag, ".head_visible"}, 32'(mq[0].t < edge_no), 32'd1);
          check({tag, ".data"}, 32'(data), 32'(mq[0].v));
        end
        check({tag, ".sender_xfer"}, 32'(sender), 32'd1);
      end else begin
        check({tag, ".data_zero"}, 32'(data), 32'd0);
      end
      if (h) begin
        check({tag, ".h_sender"}, 32'(sender), 32'd0);
        check({tag, ".h_phase"}, 32'(phase), 32'd0);
      end
      if ((cyc >= gen_cycles || pkts >= max_pkts) && src.size() == 0 && mq.size() == 0 &&
          phase == 0 && !expect_end && !sender && !h) begin
        drained = 1;
        break;
      end
      if (cyc < gen_cycles && pkts < max_pkts && src.size() < 4) begin
        sz = $urandom_range(0, 4);
        src.push_back(flit_t'($urandom));
        src.push_back(flit_t'(sz));
        for (int k = 0; k < sz; k++) src.push_back(flit_t'($urandom));
        pkts++;
      end
      rx       = (src.size() > 0) && ($urandom_range(0, 3) != 0);
      din      = rx ? src[0] : flit_t'($urandom);
      data_in  = din;
      ack_h    = h && ($urandom_range(0, 1) == 1);
      data_ack = ($urandom_range(0, 3) != 0);
      pop      = data_av && data_ack;
      wr       = rx && (mq.size() < DEPTH);
      @(posedge clock);
      edge_no++;
      if (pop && mq.size() > 0) begin
        e = mq.pop_front();
        stall = 0;
        case (phase)
          0: phase = 1;
          1: begin
            rem = int'(e.v);
            if (rem == 0) begin phase = 0; expect_end = 1; end
            else phase = 2;
          end
          default: begin
            rem--;
            if (rem == 0) begin phase = 0; expect_end = 1; end
          end
        endcase
      end else if (mq.size() > 0) begin
        stall++;
      end
      if (stall > max_stall) max_stall = stall;
      if (wr) begin
        e.v = din;
        e.t = edge_no;
        mq.push_back(e);
        void'(src.pop_front());
      end
      @(negedge clock);
    end
    check({tag, ".drained"}, 32'(drained), 32'd1);
    check({tag, ".max_stall_ok"}, 32'(max_stall < 50), 32'd1);
    rx = 1'b0; ack_h = 1'b0; data_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   npop;
    logic will_pop;

    // Reset values, during reset and after release while idle.
    do_reset(1);
    tick();
    check_outs("reset.idle", 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Packet 0x0011/0x0002/0xAAAA/0xBBBB, then size-0 packet followed by
    // another header written during the transfer.
    tbl.push_back(mk(1, 1, 16'h0011, 0, 0,  1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 16'h0002, 0, 0,  1, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 16'hAAAA, 1, 0,  1, 0, 1, 16'h0011, 1));
    tbl.push_back(mk(0, 1, 16'hBBBB, 0, 1,  1, 0, 1, 16'h0002, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 0, 1, 16'hAAAA, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 0, 1, 16'hBBBB, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 16'h1234, 0, 0,  1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 16'h0000, 0, 0,  1, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 16'h5555, 1, 0,  1, 0, 1, 16'h1234, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 0, 1, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0,  1, 0, 1, 16'h5555, 1));
    tbl.push_back(mk(0, 1, 16'h0001, 0, 1,  1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 1, 16'h7777, 0, 1,  1, 0, 1, 16'h0001, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 0, 1, 16'h7777, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 0, 0, 16'h0000, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(0);
      rx       = tbl[i].rx;
      data_in  = tbl[i].din;
      ack_h    = tbl[i].ack_h;
      data_ack = tbl[i].data_ack;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].credit, tbl[i].h, tbl[i].av,
                 tbl[i].data, tbl[i].sender);
    end

    // Fill to capacity, drop the 17th flit, then drain.
    do_reset(0);
    for (int i = 0; i < 17; i++) begin
      rx      = 1'b1;
      data_in = full_flit(i);
      tick();
      if (i == 14) check("full.credit_at15", 32'(credit_o), 32'd1);
      if (i == 15) check("full.credit_at16", 32'(credit_o), 32'd0);
      if (i == 16) check("full.credit_at17", 32'(credit_o), 32'd0);
    end
    rx = 1'b0;
    check("full.h_wait", 32'(h), 32'd1);
    ack_h = 1'b1;
    tick();
    ack_h = 1'b0;
    check("full.first_av", 32'(data_av), 32'd1);
    data_ack = 1'b1;
    npop = 0;
    for (int c = 0; c < 60 && npop < 16; c++) begin
      if (data_av) begin
        check($sformatf("full.pop%0d", npop), 32'(data), 32'(full_flit(npop)));
        npop++;
      end
      tick();
      if (c == 0) check("full.credit_restored", 32'(credit_o), 32'd1);
    end
    data_ack = 1'b0;
    check("full.pops", 32'(npop), 32'd16);
    check("full.end_sender", 32'(sender), 32'd0);
    check("full.end_av", 32'(data_av), 32'd0);
    tick();
    tick();
    check("full.no_17th", 32'(h), 32'd0);

    // Asynchronous reset after the size flit of a size-3 packet.
    do_reset(0);
    src.delete();
    src.push_back(16'h0100); src.push_back(16'h0003);
    src.push_back(16'h0001); src.push_back(16'h0002); src.push_back(16'h0003);
    ack_h = 1'b1;
    data_ack = 1'b1;
    npop = 0;
    for (int c = 0; c < 20 && npop < 2; c++) begin
      rx       = (src.size() > 0);
      data_in  = rx ? src[0] : '0;
      will_pop = data_av && data_ack;
      @(posedge clock);
      if (rx) void'(src.pop_front());
      if (will_pop) npop++;
      @(negedge clock);
    end
    check("mid.pops", 32'(npop), 32'd2);
    check("mid.sender_before", 32'(sender), 32'd1);
    rx = 1'b0; ack_h = 1'b0; data_ack = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_outs("mid.async", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("mid.empty_h%0d", c), 32'(h), 32'd0);
      check($sformatf("mid.empty_av%0d", c), 32'(data_av), 32'd0);
    end
    rx = 1'b1; data_in = 16'h0200;
    tick();
    data_in = 16'h0000;
    tick();
    rx = 1'b0;
    check("mid.new_h", 32'(h), 32'd1);
    ack_h = 1'b1;
    tick();
    ack_h = 1'b0;
    check_outs("mid.hdr", 1'b1, 1'b0, 1'b1, 16'h0200, 1'b1);
    data_ack = 1'b1;
    tick();
    check_outs("mid.size", 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
    tick();
    data_ack = 1'b0;
    check_outs("mid.end", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

`ifdef ROUTER_BUF_STATS_EN
    do_reset(0);
    check("stats.reset", pkt_count, 32'd0);
    run_traffic(1000, 3, "stats3");
    check("stats.three", pkt_count, 32'd3);
    force dut.pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count;
    @(negedge clock);
    run_traffic(1000, 1, "stats_wrap");
    check("stats.wrap", pkt_count, 32'd0);
`endif

    // Randomized traffic against the model.
    do_reset(0);
    run_traffic(3000, 1000000, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
